// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: sizing function, pointer-width limits and flag compares.
// Kept generic so single-clock and future dual-clock FIFOs agree on flag semantics.
package fifo_pkg;

  localparam int FIFO_MAX_ADDR_BITS = 16;
  localparam int FIFO_PTR_MAX_W     = FIFO_MAX_ADDR_BITS + 1;

  typedef logic [FIFO_PTR_MAX_W-1:0] fifo_ptr_t;

  function automatic int clog2(input int unsigned value);
    int          result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Pointers carry one wrap bit above the address; full means only that bit differs.
  function automatic logic ptrs_full(input fifo_ptr_t wr_ptr, input fifo_ptr_t rd_ptr,
                                     input int addr_bits);
    return (wr_ptr ^ rd_ptr) == (fifo_ptr_t'(1) << addr_bits);
  endfunction

  function automatic logic ptrs_empty(input fifo_ptr_t wr_ptr, input fifo_ptr_t rd_ptr);
    return wr_ptr == rd_ptr;
  endfunction

  function automatic logic level_ge(input int unsigned lvl, input int unsigned thresh);
    return lvl >= thresh;
  endfunction

  function automatic logic level_le(input int unsigned lvl, input int unsigned thresh);
    return lvl <= thresh;
  endfunction

endpackage

// File: rtl/fifo_mem_1clk.sv
// Single-clock storage: one write port and one registered read port.
// The read register is reset so the FIFO output starts at zero; the array itself is not.
module fifo_mem_1clk #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: pointer management, registered level/flags, overflow/underflow pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through output; default is standard read.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_BITS     = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ADDR_BITS + 1;
  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic                  full_nxt, empty_nxt, rd_valid_nxt;
  logic                  wr_acc, mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  fifo_mem_1clk #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata (wr_data),
    .re    (mem_re),
    .raddr (rd_ptr[ADDR_BITS-1:0]),
    .rdata (mem_rdata)
  );

  assign wr_acc     = wr_en && !full;
  assign wr_ptr_nxt = wr_ptr + PTR_W'(wr_acc);

`ifdef FIFO_SYNC_FWFT_EN
  // Two-deep prefetch: memory read register (stage) feeds the output register.
  logic pop, load_out, stage_valid, stage_valid_nxt;

  always_comb begin
    pop             = rd_en && rd_valid;
    load_out        = stage_valid && (!rd_valid || pop);
    mem_re          = !ptrs_empty(fifo_ptr_t'(wr_ptr), fifo_ptr_t'(rd_ptr))
                      && (!stage_valid || load_out);
    rd_ptr_nxt      = rd_ptr + PTR_W'(mem_re);
    stage_valid_nxt = mem_re || (stage_valid && !load_out);
    rd_valid_nxt    = load_out || (rd_valid && !pop);
    level_nxt       = level + PTR_W'(wr_acc) - PTR_W'(pop);
    full_nxt        = (level_nxt == PTR_W'(DEPTH));
    empty_nxt       = !rd_valid_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      stage_valid <= stage_valid_nxt;
      rd_valid    <= rd_valid_nxt;
      if (load_out) begin
        rd_data <= mem_rdata;
      end
    end
  end
`else
  always_comb begin
    mem_re       = rd_en && !empty;
    rd_ptr_nxt   = rd_ptr + PTR_W'(mem_re);
    rd_valid_nxt = mem_re;
    level_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt     = ptrs_full(fifo_ptr_t'(wr_ptr_nxt), fifo_ptr_t'(rd_ptr_nxt), ADDR_BITS);
    empty_nxt    = ptrs_empty(fifo_ptr_t'(wr_ptr_nxt), fifo_ptr_t'(rd_ptr_nxt));
  end

  assign rd_data = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_valid_nxt;
    end
  end
`endif

  // In both modes empty reflects "nothing readable", so the reject pulses share one form.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= level_ge(0, AFULL_THRESH);
      almost_empty <= level_le(0, AEMPTY_THRESH);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= level_ge(32'(level_nxt), AFULL_THRESH);
      almost_empty <= level_le(32'(level_nxt), AEMPTY_THRESH);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
`timescale 1ns/1ps
// Directed and randomised stimulus for fifo_sync, checked against a queue-based model.
// Build with FIFO_SYNC_FWFT_EN to check the first-word-fall-through variant.
module tb_fifo_sync;

  localparam int DW    = 8;
  localparam int AB    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AB:0]   level;

  fifo_sync #(
    .DATA_WIDTH    (DW),
    .ADDR_BITS     (AB),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            wedge;
  } entry_t;

  entry_t        mq[$];
  int            edge_cnt;
  int            n_checks;
  int            n_pass;
  logic [DW-1:0] exp_rd_data;
  logic          exp_rd_valid, exp_ov, exp_uf;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h",
               tag, edge_cnt, observed, expected);
    end
  endtask

  task automatic checkAllOutputs();
    int sz;
    sz = mq.size();
    checkOutput("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
    checkOutput("rd_data", 32'(rd_data), 32'(exp_rd_data));
    checkOutput("level", 32'(level), 32'(sz));
    checkOutput("full", 32'(full), 32'(sz == DEPTH));
`ifdef FIFO_SYNC_FWFT_EN
    checkOutput("empty", 32'(empty), 32'(!exp_rd_valid));
`else
    checkOutput("empty", 32'(empty), 32'(sz == 0));
`endif
    checkOutput("almost_full", 32'(almost_full), 32'(sz >= AF));
    checkOutput("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    checkOutput("overflow", 32'(overflow), 32'(exp_ov));
    checkOutput("underflow", 32'(underflow), 32'(exp_uf));
  endtask

  // One clock of stimulus: acceptance is decided from the model's pre-edge occupancy.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r);
    int     sz;
    logic   rd_ok, wr_ok;
    entry_t popped;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    sz      = mq.size();
`ifdef FIFO_SYNC_FWFT_EN
    rd_ok = r && exp_rd_valid;
`else
    rd_ok = r && (sz > 0);
`endif
    wr_ok = w && (sz < DEPTH);
    @(posedge clk);
    edge_cnt++;
    exp_ov = w && !wr_ok;
    exp_uf = r && !rd_ok;
    if (rd_ok) begin
`ifdef FIFO_SYNC_FWFT_EN
      mq.delete(0);
`else
      popped      = mq.pop_front();
      exp_rd_data = popped.data;
`endif
    end
    if (wr_ok) begin
      mq.push_back('{data: d, wedge: edge_cnt});
    end
`ifdef FIFO_SYNC_FWFT_EN
    // A stored word becomes visible two edges after its write, once it reaches the head.
    exp_rd_valid = (mq.size() > 0) && (mq[0].wedge + 2 <= edge_cnt);
    if (exp_rd_valid) begin
      exp_rd_data = mq[0].data;
    end
`else
    exp_rd_valid = rd_ok;
`endif
    @(negedge clk);
    checkAllOutputs();
  endtask

  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    exp_rd_data  = '0;
    exp_rd_valid = 1'b0;
    exp_ov       = 1'b0;
    exp_uf       = 1'b0;
    checkAllOutputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkAllOutputs();
  endtask

  initial begin
    rst      = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_data  = '0;
    edge_cnt = 0;
    n_checks = 0;
    n_pass   = 0;
    @(negedge clk);
    doReset();

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    doReset();

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(8'h45 + i), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 35);
    doReset();
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 65);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
